// File: rtl/spm_arb_pkg.sv
// -----------------------------------------------------------------------------
// spm_arb_pkg
// Shared definitions for the scratchpad arbiter: OCP command and response
// encodings, the response pipeline record, and a request decode helper.
// No ports (package).
// -----------------------------------------------------------------------------
package spm_arb_pkg;

    // OCP master command encodings (any other value is treated as idle)
    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;

    // OCP slave response encodings (ERR is reserved, never produced)
    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    // Wide enough for the largest supported master count (8)
    localparam int IDX_W = 3;

    // One-deep response pipeline: which master gets DVA next cycle, and
    // whether it should see the SPM read data
    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             is_read;
    } resp_pipe_t;

    // Only WR and RD request the SPM; illegal encodings never request
    function automatic logic is_request(input logic [2:0] cmd);
        return (cmd == CMD_WR) || (cmd == CMD_RD);
    endfunction

endpackage

// File: rtl/spm_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first requester at or after the
// pointer, wrapping modulo NUM_MASTERS.
// Ports:
//   i_req   [NUM_MASTERS-1:0]  request vector
//   i_ptr   [IDX_W-1:0]        highest-priority index this cycle
//   o_grant [NUM_MASTERS-1:0]  one-hot grant (zero when nobody requests)
//   o_idx   [IDX_W-1:0]        index of the granted master (0 when none)
//   o_any                      a grant was issued
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [NUM_MASTERS-1:0] o_grant,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_any
);

    always_comb begin
        int cand;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        cand    = 0;
        // Walk priority order ptr, ptr+1, ... ; the inner loop keeps every
        // bit select constant so the search unrolls into a flat priority mux
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = int'(i_ptr) + k;
            if (cand >= NUM_MASTERS) begin
                cand = cand - NUM_MASTERS;
            end
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!o_any && (j == cand) && i_req[j]) begin
                    o_any      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/spm_arbiter.sv
// -----------------------------------------------------------------------------
// spm_arbiter
// Shares one single-ported scratchpad between NUM_MASTERS OCP requesters.
// One command is accepted per cycle (round-robin), driven straight onto the
// SPM port, and the response (DVA, plus read data for RD) is routed back to
// the issuing master exactly one cycle later.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   m_cmd/m_addr/m_data/m_byteen  flattened per-master OCP command fields
//   s_cmdaccept                one-hot accept, combinational
//   s_resp/s_data              per-master response and read data
//   spm_addr/spm_data/spm_byteen/spm_we  SPM command port
//   spm_rdata                  SPM read data, valid the cycle after the address
// -----------------------------------------------------------------------------
module spm_arbiter
    import spm_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [3*NUM_MASTERS-1:0]              m_cmd,
    input  logic [ADDR_WIDTH*NUM_MASTERS-1:0]     m_addr,
    input  logic [DATA_WIDTH*NUM_MASTERS-1:0]     m_data,
    input  logic [(DATA_WIDTH/8)*NUM_MASTERS-1:0] m_byteen,
    output logic [NUM_MASTERS-1:0]                s_cmdaccept,
    output logic [2*NUM_MASTERS-1:0]              s_resp,
    output logic [DATA_WIDTH*NUM_MASTERS-1:0]     s_data,
    output logic [ADDR_WIDTH-1:0]                 spm_addr,
    output logic [DATA_WIDTH-1:0]                 spm_data,
    output logic [DATA_WIDTH/8-1:0]               spm_byteen,
    output logic                                  spm_we,
    input  logic [DATA_WIDTH-1:0]                 spm_rdata
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    logic [2:0]            w_cmd  [NUM_MASTERS];
    logic [ADDR_WIDTH-1:0] w_addr [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] w_data [NUM_MASTERS];
    logic [BE_W-1:0]       w_be   [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_grant_raw;
    logic [NUM_MASTERS-1:0] w_grant;
    logic [PTR_W-1:0]      w_idx;
    logic [PTR_W-1:0]      w_sel;
    logic                  w_any_raw;
    logic                  w_any;
    logic [PTR_W-1:0]      r_ptr;
    resp_pipe_t            r_resp;

    // Unflatten the per-master buses
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
            assign w_cmd[gi]  = m_cmd[gi*3 +: 3];
            assign w_addr[gi] = m_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_data[gi] = m_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign w_be[gi]   = m_byteen[gi*BE_W +: BE_W];
            assign w_req[gi]  = is_request(w_cmd[gi]);
        end
    endgenerate

    rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (PTR_W)
    ) u_rr (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant_raw),
        .o_idx   (w_idx),
        .o_any   (w_any_raw)
    );

    // Nothing is accepted while reset is held: the response register is
    // forced clear, so an accepted command would never be answered.
    assign w_any   = w_any_raw & ~reset;
    assign w_grant = w_grant_raw & {NUM_MASTERS{~reset}};
    assign w_sel   = w_any ? w_idx : '0;

    assign s_cmdaccept = w_grant;
    assign spm_addr    = w_addr[w_sel];
    assign spm_data    = w_data[w_sel];
    assign spm_byteen  = w_any ? w_be[w_sel] : '0;
    assign spm_we      = w_any && (w_cmd[w_sel] == CMD_WR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr  <= '0;
            r_resp <= '0;
        end else begin
            if (w_any) begin
                r_ptr <= (int'(w_idx) == NUM_MASTERS - 1) ? '0 : w_idx + 1'b1;
            end
            r_resp.valid   <= w_any;
            r_resp.idx     <= IDX_W'(w_idx);
            r_resp.is_read <= w_any && (w_cmd[w_sel] == CMD_RD);
        end
    end

    // Response fan-out: only the pending master sees DVA; read data is
    // passed through from the SPM without a register since it already
    // arrives one cycle after the address.
    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_resp
            logic w_hit;
            assign w_hit = r_resp.valid && (r_resp.idx == IDX_W'(gi));
            assign s_resp[gi*2 +: 2] = w_hit ? RESP_DVA : RESP_NULL;
            assign s_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                (w_hit && r_resp.is_read) ? spm_rdata : '0;
        end
    endgenerate

endmodule

// File: tb/tb_spm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spm_arbiter
// Directed bench: a 2-master instance with a small SPM model driven from a
// per-cycle vector table, a 4-master instance for pointer wrap, and
// hand-written sequences around asynchronous reset.
// -----------------------------------------------------------------------------
module tb_spm_arbiter;

    localparam logic [2:0] I = 3'b000;
    localparam logic [2:0] W = 3'b001;
    localparam logic [2:0] R = 3'b010;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- 2-master instance ----------------
    logic [5:0]  m_cmd2;
    logic [31:0] m_addr2;
    logic [63:0] m_data2;
    logic [7:0]  m_be2;
    logic [1:0]  acc2;
    logic [3:0]  resp2;
    logic [63:0] sdata2;
    logic [15:0] spm_addr2;
    logic [31:0] spm_data2;
    logic [3:0]  spm_be2;
    logic        spm_we2;
    logic [31:0] spm_rdata2;

    spm_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut2 (
        .clk(clk), .reset(reset),
        .m_cmd(m_cmd2), .m_addr(m_addr2), .m_data(m_data2), .m_byteen(m_be2),
        .s_cmdaccept(acc2), .s_resp(resp2), .s_data(sdata2),
        .spm_addr(spm_addr2), .spm_data(spm_data2), .spm_byteen(spm_be2),
        .spm_we(spm_we2), .spm_rdata(spm_rdata2)
    );

    // SPM model: write at the edge, registered read of the current address
    logic [31:0] mem [64];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (spm_we2) begin
            for (int b = 0; b < 4; b++)
                if (spm_be2[b]) mem[spm_addr2[7:2]][b*8 +: 8] <= spm_data2[b*8 +: 8];
        end
        spm_rdata2 <= mem[spm_addr2[7:2]];
    end

    // ---------------- 4-master instance ----------------
    logic [11:0]  m_cmd4;
    logic [63:0]  m_addr4;
    logic [127:0] m_data4;
    logic [15:0]  m_be4;
    logic [3:0]   acc4;
    logic [7:0]   resp4;
    logic [127:0] sdata4;
    logic [15:0]  spm_addr4;
    logic [31:0]  spm_data4;
    logic [3:0]   spm_be4;
    logic         spm_we4;
    logic [31:0]  spm_rdata4;

    spm_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut4 (
        .clk(clk), .reset(reset),
        .m_cmd(m_cmd4), .m_addr(m_addr4), .m_data(m_data4), .m_byteen(m_be4),
        .s_cmdaccept(acc4), .s_resp(resp4), .s_data(sdata4),
        .spm_addr(spm_addr4), .spm_data(spm_data4), .spm_byteen(spm_be4),
        .spm_we(spm_we4), .spm_rdata(spm_rdata4)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set2(input int m, input logic [2:0] c, input logic [15:0] a, input logic [31:0] d);
        m_cmd2[m*3 +: 3]   = c;
        m_addr2[m*16 +: 16] = a;
        m_data2[m*32 +: 32] = d;
        m_be2[m*4 +: 4]     = 4'hF;
    endtask

    task automatic set4(input int m, input logic [2:0] c, input logic [15:0] a, input logic [31:0] d);
        m_cmd4[m*3 +: 3]    = c;
        m_addr4[m*16 +: 16] = a;
        m_data4[m*32 +: 32] = d;
        m_be4[m*4 +: 4]     = 4'hF;
    endtask

    typedef struct {
        logic [2:0]  c0; logic [15:0] a0; logic [31:0] d0;
        logic [2:0]  c1; logic [15:0] a1; logic [31:0] d1;
        logic [1:0]  acc;
        logic        we;
        logic [3:0]  resp;
        logic [31:0] sd0;
        logic [31:0] sd1;
    } vec_t;

    function automatic vec_t mk(
        input logic [2:0] c0, input logic [15:0] a0, input logic [31:0] d0,
        input logic [2:0] c1, input logic [15:0] a1, input logic [31:0] d1,
        input logic [1:0] acc, input logic we, input logic [3:0] resp,
        input logic [31:0] sd0, input logic [31:0] sd1);
        vec_t v;
        v.c0 = c0; v.a0 = a0; v.d0 = d0;
        v.c1 = c1; v.a1 = a1; v.d1 = d1;
        v.acc = acc; v.we = we; v.resp = resp; v.sd0 = sd0; v.sd1 = sd1;
        return v;
    endfunction

    localparam int NV = 21;
    vec_t vt [NV];

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [15:0] exp_addr;

        // Per-cycle vectors; resp/sd columns are the answer to the previous row
        // Full contention, both reading continuously from pointer 0
        vt[0]  = mk(R,16'h0008,0, R,16'h000C,0, 2'b01,0,4'b0000,0,0);
        vt[1]  = mk(R,16'h0008,0, R,16'h000C,0, 2'b10,0,4'b0001,32'hA000_0002,0);
        vt[2]  = mk(R,16'h0008,0, R,16'h000C,0, 2'b01,0,4'b0100,0,32'hA000_0003);
        vt[3]  = mk(R,16'h0008,0, R,16'h000C,0, 2'b10,0,4'b0001,32'hA000_0002,0);
        vt[4]  = mk(R,16'h0008,0, R,16'h000C,0, 2'b01,0,4'b0100,0,32'hA000_0003);
        vt[5]  = mk(R,16'h0008,0, R,16'h000C,0, 2'b10,0,4'b0001,32'hA000_0002,0);
        vt[6]  = mk(I,0,0, I,0,0,                2'b00,0,4'b0100,0,32'hA000_0003);
        // Single master write then read back
        vt[7]  = mk(W,16'h0004,32'hDEADBEEF, I,0,0, 2'b01,1,4'b0000,0,0);
        vt[8]  = mk(R,16'h0004,0, I,0,0,            2'b01,0,4'b0001,0,0);
        vt[9]  = mk(I,0,0, I,0,0,                   2'b00,0,4'b0001,32'hDEADBEEF,0);
        // RAW across masters
        vt[10] = mk(W,16'h0020,32'h12345678, I,0,0, 2'b01,1,4'b0000,0,0);
        vt[11] = mk(I,0,0, R,16'h0020,0,            2'b10,0,4'b0001,0,0);
        vt[12] = mk(I,0,0, I,0,0,                   2'b00,0,4'b0100,0,32'h12345678);
        // m1 holds a read while m0 streams writes
        vt[13] = mk(W,16'h0030,32'h11111111, R,16'h0010,0, 2'b01,1,4'b0000,0,0);
        vt[14] = mk(W,16'h0034,32'h22222222, R,16'h0010,0, 2'b10,0,4'b0001,0,0);
        vt[15] = mk(W,16'h0034,32'h22222222, I,0,0,        2'b01,1,4'b0100,0,32'hA000_0004);
        vt[16] = mk(W,16'h0038,32'h33333333, I,0,0,        2'b01,1,4'b0001,0,0);
        vt[17] = mk(I,0,0, I,0,0,                          2'b00,0,4'b0001,0,0);
        // Illegal encodings never request; then read back the last write
        vt[18] = mk(3'b111,16'h0038,0, 3'b100,16'h0038,0, 2'b00,0,4'b0000,0,0);
        vt[19] = mk(3'b011,16'h0038,0, R,16'h0038,0,      2'b10,0,4'b0000,0,0);
        vt[20] = mk(I,0,0, I,0,0,                         2'b00,0,4'b0100,0,32'h33333333);

        m_cmd2 = '0; m_addr2 = '0; m_data2 = '0; m_be2 = '0;
        m_cmd4 = '0; m_addr4 = '0; m_data4 = '0; m_be4 = '0;
        spm_rdata4 = 32'h5A5A_5A5A;

        // ---- reset state, with a write request present ----
        set2(0, W, 16'h0004, 32'h0000_0001);
        set4(2, R, 16'h0040, 32'h0);
        #12;
        chk("rst_accept2", 64'(acc2), 64'h0);
        chk("rst_resp2",   64'(resp2), 64'h0);
        chk("rst_sdata2",  sdata2, 64'h0);
        chk("rst_we2",     64'(spm_we2), 64'h0);
        chk("rst_byteen2", 64'(spm_be2), 64'h0);
        chk("rst_accept4", 64'(acc4), 64'h0);
        $display("reset check: acc2=%b resp2=%b we2=%b acc4=%b", acc2, resp2, spm_we2, acc4);
        set2(0, I, 16'h0, 32'h0);
        set4(2, I, 16'h0, 32'h0);
        @(posedge clk); #2;
        reset = 1'b0;

        // ---- pointer wrap on 4 masters ----
        set4(3, R, 16'h0040, 32'hC0DE_0003);
        @(negedge clk);
        chk("wrap_acc_m3", 64'(acc4), 64'b1000);
        chk("wrap_spm_addr", 64'(spm_addr4), 64'h0040);
        chk("wrap_spm_data", 64'(spm_data4), 64'hC0DE_0003);
        chk("wrap_byteen", 64'(spm_be4), 64'hF);
        $display("wrap cyc0: acc4=%b resp4=%b", acc4, resp4);
        @(posedge clk); #1;
        set4(1, R, 16'h0044, 32'h0);
        set4(3, R, 16'h0048, 32'h0);
        @(negedge clk);
        chk("wrap_acc_m1", 64'(acc4), 64'b0010);
        chk("wrap_resp_m3", 64'(resp4), 64'b0100_0000);
        chk("wrap_sdata_m3", sdata4[127:64], {32'h5A5A_5A5A, 32'h0});
        $display("wrap cyc1: acc4=%b resp4=%b", acc4, resp4);
        @(posedge clk); #1;
        set4(1, I, 16'h0, 32'h0);
        @(negedge clk);
        chk("wrap_acc_m3b", 64'(acc4), 64'b1000);
        chk("wrap_resp_m1", 64'(resp4), 64'b0000_0100);
        chk("wrap_sdata_m1", sdata4[63:0], {32'h5A5A_5A5A, 32'h0});
        $display("wrap cyc2: acc4=%b resp4=%b", acc4, resp4);
        @(posedge clk); #1;
        set4(3, I, 16'h0, 32'h0);
        @(negedge clk);
        chk("wrap_acc_idle", 64'(acc4), 64'h0);
        chk("wrap_we_idle", 64'(spm_we4), 64'h0);
        chk("wrap_resp_m3b", 64'(resp4), 64'b0100_0000);
        $display("wrap cyc3: acc4=%b resp4=%b", acc4, resp4);
        @(posedge clk); #1;

        // ---- table-driven sequence on 2 masters ----
        for (int i = 0; i < NV; i++) begin
            set2(0, vt[i].c0, vt[i].a0, vt[i].d0);
            set2(1, vt[i].c1, vt[i].a1, vt[i].d1);
            @(negedge clk);
            chk($sformatf("v%0d_accept", i), 64'(acc2), 64'(vt[i].acc));
            chk($sformatf("v%0d_we", i), 64'(spm_we2), 64'(vt[i].we));
            chk($sformatf("v%0d_byteen", i), 64'(spm_be2), (vt[i].acc != 2'b00) ? 64'hF : 64'h0);
            chk($sformatf("v%0d_resp", i), 64'(resp2), 64'(vt[i].resp));
            chk($sformatf("v%0d_sdata0", i), 64'(sdata2[31:0]), 64'(vt[i].sd0));
            chk($sformatf("v%0d_sdata1", i), 64'(sdata2[63:32]), 64'(vt[i].sd1));
            if (vt[i].acc != 2'b00) begin
                exp_addr = vt[i].acc[1] ? vt[i].a1 : vt[i].a0;
                chk($sformatf("v%0d_spm_addr", i), 64'(spm_addr2), 64'(exp_addr));
            end
            $display("vec %0d: acc=%b we=%b resp=%b sd0=%h sd1=%h", i, acc2, spm_we2,
                     resp2, sdata2[31:0], sdata2[63:32]);
            @(posedge clk); #1;
        end

        // ---- asynchronous reset with a read response pending ----
        set2(0, R, 16'h0008, 32'h0);
        set2(1, I, 16'h0, 32'h0);
        @(negedge clk);
        chk("rr_pre_accept", 64'(acc2), 64'b01);
        @(posedge clk); #1;
        chk("rr_pending_dva", 64'(resp2), 64'b0001);
        set2(0, W, 16'h0008, 32'hBAD0_BAD0);
        set2(1, R, 16'h000C, 32'h0);
        #1 reset = 1'b1;
        #1;
        chk("rr_resp_dropped", 64'(resp2), 64'h0);
        chk("rr_sdata_dropped", sdata2, 64'h0);
        chk("rr_accept_in_rst", 64'(acc2), 64'h0);
        chk("rr_we_in_rst", 64'(spm_we2), 64'h0);
        chk("rr_byteen_in_rst", 64'(spm_be2), 64'h0);
        $display("reset mid-op: acc=%b resp=%b we=%b", acc2, resp2, spm_we2);
        @(posedge clk); #1;
        chk("rr_we_in_rst2", 64'(spm_we2), 64'h0);
        chk("rr_resp_in_rst2", 64'(resp2), 64'h0);
        set2(0, R, 16'h0008, 32'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rr_first_grant_m0", 64'(acc2), 64'b01);
        chk("rr_no_replay", 64'(resp2), 64'h0);
        $display("post-reset cyc0: acc=%b resp=%b", acc2, resp2);
        @(posedge clk); #1;
        set2(0, I, 16'h0, 32'h0);
        @(negedge clk);
        chk("rr_second_grant_m1", 64'(acc2), 64'b10);
        chk("rr_resp_m0", 64'(resp2), 64'b0001);
        chk("rr_sdata_m0", 64'(sdata2[31:0]), 64'hA000_0002);
        $display("post-reset cyc1: acc=%b resp=%b sd0=%h", acc2, resp2, sdata2[31:0]);
        @(posedge clk); #1;
        set2(1, I, 16'h0, 32'h0);
        @(negedge clk);
        chk("rr_resp_m1", 64'(resp2), 64'b0100);
        chk("rr_sdata_m1", 64'(sdata2[63:32]), 64'hA000_0003);
        $display("post-reset cyc2: acc=%b resp=%b sd1=%h", acc2, resp2, sdata2[63:32]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spm_arbiter.md
Name: spm_arbiter

Overview:
Round-robin arbiter that shares one single-ported data scratchpad (SPM) between NUM_MASTERS OCP-style requesters, e.g. the core data path and a DMA/NoC engine. It accepts at most one command per cycle, drives the SPM's address, data, byte-enable and write-enable lines, and routes the one-cycle-late SPM response back to the master that issued the command. Requesters see standard M_Cmd/S_CmdAccept/S_Resp handshakes. The SPM sees a plain synchronous memory port.

Parameters:
NUM_MASTERS, 2, number of requesters (2..8)
ADDR_WIDTH, 16, byte/word address width passed unchanged to the SPM
DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
m_cmd  in  3*NUM_MASTERS  per-master command: IDLE=000, WR=001, RD=010, others treated as IDLE
m_addr  in  ADDR_WIDTH*NUM_MASTERS  per-master address
m_data  in  DATA_WIDTH*NUM_MASTERS  per-master write data
m_byteen  in  (DATA_WIDTH/8)*NUM_MASTERS  per-master byte enables
s_cmdaccept  out  NUM_MASTERS  one-hot; the command of master i is taken this cycle
s_resp  out  2*NUM_MASTERS  per-master response: NULL=00, DVA=01
s_data  out  DATA_WIDTH*NUM_MASTERS  per-master read data, valid with DVA after a RD
spm_addr  out  ADDR_WIDTH  SPM address
spm_data  out  DATA_WIDTH  SPM write data
spm_byteen  out  DATA_WIDTH/8  SPM byte enables
spm_we  out  1  SPM write strobe
spm_rdata  in  DATA_WIDTH  SPM read data, valid the cycle after the address

Behaviour:
- A master requests when m_cmd is WR or RD. It holds cmd, addr, data and byteen stable until it sees s_cmdaccept high.
- Grant is combinational in the same cycle:
  - Choose the first requesting master at or after rr_ptr, wrapping modulo NUM_MASTERS.
  - Raise s_cmdaccept for that master only.
  - Drive spm_addr, spm_data and spm_byteen from the granted master.
  - spm_we=1 only for a granted WR.
- rr_ptr (registered) updates on any grant to (granted+1) mod NUM_MASTERS. With no request it holds.
- With no grant: spm_we=0, spm_byteen=0, spm_addr and spm_data are don't-care (drive master 0's values).
- Response pipeline register stores {valid, master index, is_read}, loaded on every grant and cleared otherwise.
- Next cycle, the pending master receives s_resp=DVA, for reads and writes alike.
  - s_data of that master = spm_rdata for a read, 0 for a write.
  - All other masters see s_resp=NULL and s_data=0.
- Throughput: one command per cycle total. Back-to-back grants are allowed, including to the same master when it is the only requester. A response and a new grant may occur in the same cycle.
- Latency: accept at cycle t, DVA at t+1, fixed and independent of contention.
- Fairness: with all masters requesting continuously, each master is granted exactly once per NUM_MASTERS cycles.
- RAW ordering: a RD granted the cycle after a WR to the same address returns the new data. This relies on SPM write-before-next-read semantics; the arbiter adds no bypass.
- Reset (async, any time, including with a response pending):
  - rr_ptr=0 and the response register is cleared.
  - s_resp all NULL, s_data all 0, s_cmdaccept all 0.
  - spm_we=0, spm_byteen=0.
  - In-flight responses are dropped, not replayed.
  - The first cycle after deassertion arbitrates normally from master 0.
- Illegal m_cmd encodings never request and never receive accept or DVA.

Decomposition:
- Shared package spm_arb_pkg: OCP cmd constants (IDLE/WR/RD), resp constants (NULL/DVA/ERR reserved), and a response-pipe struct typedef {valid, idx, is_read}.
- One natural sub-module: rr_arbiter (NUM_MASTERS request vector + rr_ptr in -> one-hot grant, index, any_grant out; purely combinational). spm_arbiter owns the pointer, the muxing and the response register.

Test Plan:
1. Single master: m0 WR addr 0x0004 data 0xDEADBEEF byteen 0xF, then RD 0x0004.
   -> accept same cycle, DVA next cycle each; the read returns 0xDEADBEEF; spm_we=1 only in the WR cycle.
2. Full contention: NUM_MASTERS=2, both RD continuously for 6 cycles, rr_ptr=0 after reset.
   -> grant order m0,m1,m0,m1,m0,m1; each DVA arrives one cycle after its accept with the correct address's data.
3. Wrap and pointer hold: NUM_MASTERS=4, only m3 requests once, then m1 and m3 together.
   -> m3 granted, rr_ptr=0; next grant m1, then m3.
4. Stalled master: m1 holds RD 0x0010 while m0 issues 3 back-to-back WRs.
   -> m1 accepted no later than the 2nd cycle; its m_addr stays stable until s_cmdaccept[1]=1.
5. RAW: m0 WR 0x0020=0x12345678, m1 RD 0x0020 the next cycle.
   -> m1 DVA with 0x12345678.
6. Reset mid-operation: assert reset asynchronously (mid-cycle) the cycle after a RD is accepted.
   -> s_resp stays NULL, no DVA after release, spm_we=0 during reset; the first post-reset grant goes to the lowest-indexed requester.
